muldiv_unit: RTL and testbench



---
 rtl/mips_pkg.sv | 18 +
 rtl/muldiv_core_step.sv | 42 ++++
 rtl/muldiv_unit.sv | 158 +++++++++++++++
 tb/tb_muldiv_unit.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared encodings for the MIPS32 multiply/divide unit
// Contents:
//   MD_MULTU/MD_MULT/MD_DIVU/MD_DIV : 2-bit op encodings for muldiv_unit.op
//   md_state_t                      : muldiv_unit FSM states (IDLE, RUN, FIXUP)
package mips_pkg;

    localparam logic [1:0] MD_MULTU = 2'b00;
    localparam logic [1:0] MD_MULT  = 2'b01;
    localparam logic [1:0] MD_DIVU  = 2'b10;
    localparam logic [1:0] MD_DIV   = 2'b11;

    typedef enum logic [1:0] {
        MD_IDLE  = 2'b00,
        MD_RUN   = 2'b01,
        MD_FIXUP = 2'b10
    } md_state_t;

endpackage

// File: rtl/muldiv_core_step.sv
// rtl/muldiv_core_step.sv - one iteration of the shift-add multiply / restoring divide
// Ports:
//   acc      in  2*WIDTH  accumulator: multiply {partial product, multiplier},
//                         divide {remainder, dividend/quotient}
//   opnd     in  WIDTH    multiplicand magnitude (multiply) or divisor magnitude (divide)
//   is_div   in  1        selects the divide iteration
//   acc_next out 2*WIDTH  accumulator after this iteration (bit 0 is 0 when dividing)
//   q_bit    out 1        quotient bit produced by this divide iteration (0 when multiplying)
module muldiv_core_step #(
    parameter int WIDTH = 32
) (
    input  logic [2*WIDTH-1:0] acc,
    input  logic [WIDTH-1:0]   opnd,
    input  logic               is_div,
    output logic [2*WIDTH-1:0] acc_next,
    output logic               q_bit
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] trial;

    always_comb begin
        acc_next = '0;
        q_bit    = 1'b0;
        // Multiply: add multiplicand into the upper half when the current
        // multiplier bit is set, then shift the whole accumulator right.
        sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? opnd : '0)};
        // Divide: the remainder shifted left with the next dividend bit,
        // minus the divisor. A borrow in the top bit means "restore".
        trial = acc[2*WIDTH-1:WIDTH-1] - {1'b0, opnd};
        if (is_div) begin
            q_bit = ~trial[WIDTH];
            if (trial[WIDTH])
                acc_next = {acc[2*WIDTH-2:0], 1'b0};
            else
                acc_next = {trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
        end else begin
            acc_next = {sum, acc[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative MIPS32 multiply/divide unit with HI/LO registers
// Build option: MULDIV_DIV_EN enables DIV/DIVU; without it divide starts are ignored.
// Ports:
//   clk, rst     in   clock, asynchronous active-high reset
//   start, op    in   launch (IDLE only) and operation code (mips_pkg MD_*)
//   a, b         in   rs / rt operands
//   hi_we, lo_we in   MTHI / MTLO strobes (IDLE only), data on wdata
//   busy         out  operation in progress (state != IDLE)
//   done         out  one-cycle pulse after HI/LO are written with a result
//   hi, lo       out  architectural HI / LO
module muldiv_unit
    import mips_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH);

    md_state_t          state_q, state_d;
    logic [CW-1:0]      cnt_q;
    logic [2*WIDTH-1:0] acc_q, acc_step;
    logic [WIDTH-1:0]   opnd_q;
    logic               neg_res_q, neg_rem_q, bzero_q, done_q, q_bit;
    logic [WIDTH-1:0]   hi_q, lo_q;

    logic               op_ok, new_div, is_signed, a_neg, b_neg, accept, is_div;
    logic [WIDTH-1:0]   a_mag, b_mag;

`ifdef MULDIV_DIV_EN
    logic is_div_q;
    assign op_ok   = 1'b1;
    assign new_div = (op == MD_DIVU) || (op == MD_DIV);
    assign is_div  = is_div_q;
`else
    assign op_ok   = (op == MD_MULTU) || (op == MD_MULT);
    assign new_div = 1'b0;
    assign is_div  = 1'b0;
`endif

    assign is_signed = (op == MD_MULT) || (op == MD_DIV);
    assign a_neg     = is_signed & a[WIDTH-1];
    assign b_neg     = is_signed & b[WIDTH-1];
    // -2^(WIDTH-1) maps onto itself, which is the correct unsigned magnitude.
    assign a_mag     = a_neg ? -a : a;
    assign b_mag     = b_neg ? -b : b;
    assign accept    = start && op_ok && (state_q == MD_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= MD_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            MD_IDLE:  if (accept) state_d = MD_RUN;
            MD_RUN:   if (cnt_q == '0) state_d = MD_FIXUP;
            MD_FIXUP: state_d = MD_IDLE;
            default:  state_d = MD_IDLE;
        endcase
    end

    assign busy = (state_q != MD_IDLE);

    muldiv_core_step #(.WIDTH(WIDTH)) u_step (
        .acc      (acc_q),
        .opnd     (opnd_q),
        .is_div   (is_div),
        .acc_next (acc_step),
        .q_bit    (q_bit)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q     <= '0;
            acc_q     <= '0;
            opnd_q    <= '0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            bzero_q   <= 1'b0;
`ifdef MULDIV_DIV_EN
            is_div_q  <= 1'b0;
`endif
        end else begin
            case (state_q)
                MD_IDLE: if (accept) begin
                    cnt_q     <= CW'(WIDTH - 1);
                    neg_res_q <= a_neg ^ b_neg;
                    neg_rem_q <= a_neg;
                    bzero_q   <= (b == '0);
                    // Multiply keeps the multiplier in the low half; divide
                    // keeps the dividend there and shifts quotient bits in.
                    acc_q     <= {{WIDTH{1'b0}}, (new_div ? a_mag : b_mag)};
                    opnd_q    <= new_div ? b_mag : a_mag;
`ifdef MULDIV_DIV_EN
                    is_div_q  <= new_div;
`endif
                end
                MD_RUN: begin
                    acc_q <= {acc_step[2*WIDTH-1:1], acc_step[0] | q_bit};
                    if (cnt_q != '0) cnt_q <= cnt_q - CW'(1);
                end
                default: ;
            endcase
        end
    end

    logic [2*WIDTH-1:0] prod_res;
    logic [WIDTH-1:0]   quo_res, rem_res;

    assign prod_res = neg_res_q ? -acc_q : acc_q;
    // Divide by zero yields all-ones quotient; the remainder path already
    // reproduces a because no subtraction ever borrows against a zero divisor.
    assign quo_res  = bzero_q   ? '1 :
                      neg_res_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    assign rem_res  = neg_rem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hi_q   <= '0;
            lo_q   <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= (state_q == MD_FIXUP);
            if (state_q == MD_FIXUP) begin
                if (is_div) begin
                    hi_q <= rem_res;
                    lo_q <= quo_res;
                end else begin
                    hi_q <= prod_res[2*WIDTH-1:WIDTH];
                    lo_q <= prod_res[WIDTH-1:0];
                end
            end else if (state_q == MD_IDLE) begin
                if (hi_we) hi_q <= wdata;
                if (lo_we) lo_q <= wdata;
            end
        end
    end

    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - self-checking bench for muldiv_unit (either MULDIV_DIV_EN build)
module tb_muldiv_unit;
    import mips_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] a = '0, b = '0, wdata = '0;
    logic        hi_we = 1'b0, lo_we = 1'b0;
    logic        busy, done;
    logic [31:0] hi, lo;

    int vectors = 0;
    int errors  = 0;

    muldiv_unit #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
        .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
        .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

`ifdef MULDIV_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    function automatic void model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                                  output logic [31:0] eh, output logic [31:0] el);
        logic [63:0]        p;
        logic signed [63:0] sx, sy, sp;
        case (o)
            MD_MULTU: begin
                p = {32'b0, x} * {32'b0, y};
                eh = p[63:32]; el = p[31:0];
            end
            MD_MULT: begin
                sx = {{32{x[31]}}, x};
                sy = {{32{y[31]}}, y};
                sp = sx * sy;
                eh = sp[63:32]; el = sp[31:0];
            end
            MD_DIVU: begin
                if (y == 0) begin eh = x; el = 32'hFFFF_FFFF; end
                else begin eh = x % y; el = x / y; end
            end
            default: begin
                if (y == 0) begin eh = x; el = 32'hFFFF_FFFF; end
                else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin eh = 0; el = 32'h8000_0000; end
                else begin eh = $signed(x) % $signed(y); el = $signed(x) / $signed(y); end
            end
        endcase
    endfunction

    // Called at a negedge; counts negedges with busy high until it drops.
    task automatic wait_idle(inout int bcyc, output bit tmo);
        tmo = 1'b0;
        while (busy) begin
            bcyc++;
            if (bcyc > 200) begin tmo = 1'b1; break; end
            @(negedge clk);
        end
    endtask

    // Called at a negedge; returns at the negedge where busy has fallen.
    task automatic launch(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                          output int bcyc, output bit done_seen, output bit tmo);
        start = 1'b1; op = o; a = x; b = y;
        @(posedge clk); #1 start = 1'b0;
        @(negedge clk);
        bcyc = 0;
        wait_idle(bcyc, tmo);
        done_seen = done;
    endtask

    task automatic mt_write(input logic [31:0] hv, input logic [31:0] lv);
        hi_we = 1'b1; wdata = hv;
        @(posedge clk); #1 hi_we = 1'b0; lo_we = 1'b1; wdata = lv;
        @(posedge clk); #1 lo_we = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        vectors++; if (busy !== 1'b0)   begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        vectors++; if (done !== 1'b0)   begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
        vectors++; if (hi !== 32'h0)    begin errors++; $display("FAIL reset_hi: got %h expected 0", hi); end
        vectors++; if (lo !== 32'h0)    begin errors++; $display("FAIL reset_lo: got %h expected 0", lo); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_mthi_mtlo;
        mt_write(32'hDEAD_BEEF, 32'h0BAD_F00D);
        vectors++; if (hi !== 32'hDEAD_BEEF) begin errors++; $display("FAIL mthi: got %h expected deadbeef", hi); end
        vectors++; if (lo !== 32'h0BAD_F00D) begin errors++; $display("FAIL mtlo: got %h expected 0badf00d", lo); end
    endtask

    task automatic test_directed;
        logic [1:0]  ops [8] = '{MD_MULTU, MD_MULT, MD_DIV, MD_DIVU, MD_DIV, MD_DIV, MD_MULT, MD_DIVU};
        logic [31:0] as  [8] = '{32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'h1234, 32'h8000_0000,
                                 32'hFFFF_FF00, 32'h8000_0000, 32'hFFFF_FFFF};
        logic [31:0] bs  [8] = '{32'd6, 32'h2, 32'h2, 32'h0, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 32'h10};
        logic [31:0] eh, el;
        int bcyc; bit dn, tmo;
        for (int i = 0; i < 8; i++) begin
            if (ops[i][1] && !DIV_EN) continue;
            model(ops[i], as[i], bs[i], eh, el);
            launch(ops[i], as[i], bs[i], bcyc, dn, tmo);
            vectors++; if (tmo) begin errors++; $display("FAIL dir%0d_timeout: busy stuck high", i); end
            vectors++; if (bcyc != 33) begin errors++; $display("FAIL dir%0d_busy_cycles: got %0d expected 33", i, bcyc); end
            vectors++; if (dn !== 1'b1) begin errors++; $display("FAIL dir%0d_done: got %b expected 1", i, dn); end
            vectors++; if (hi !== eh) begin errors++; $display("FAIL dir%0d_hi: got %h expected %h", i, hi, eh); end
            vectors++; if (lo !== el) begin errors++; $display("FAIL dir%0d_lo: got %h expected %h", i, lo, el); end
            @(negedge clk);
            vectors++; if (done !== 1'b0) begin errors++; $display("FAIL dir%0d_done_width: got %b expected 0", i, done); end
        end
    endtask

    task automatic test_random;
        logic [1:0]  o;
        logic [31:0] x, y, eh, el;
        int bcyc; bit dn, tmo;
        for (int n = 0; n < 24; n++) begin
            o = 2'($urandom_range(0, DIV_EN ? 3 : 1));
            x = $urandom; y = $urandom;
            case ($urandom_range(0, 7))
                0: y = 0;
                1: y = 32'hFFFF_FFFF;
                2: x = 32'h8000_0000;
                3: y = 32'($urandom_range(1, 15));
                default: ;
            endcase
            model(o, x, y, eh, el);
            launch(o, x, y, bcyc, dn, tmo);
            vectors++; if (tmo || bcyc != 33 || dn !== 1'b1) begin
                errors++; $display("FAIL rnd%0d_timing: busy %0d done %b expected 33 and 1", n, bcyc, dn);
            end
            vectors++; if (hi !== eh) begin errors++; $display("FAIL rnd%0d_hi op%0d %h,%h: got %h expected %h", n, o, x, y, hi, eh); end
            vectors++; if (lo !== el) begin errors++; $display("FAIL rnd%0d_lo op%0d %h,%h: got %h expected %h", n, o, x, y, lo, el); end
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] eh, el;
        int bcyc; bit dn, tmo;
        launch(MD_MULTU, 32'h0001_0003, 32'h0002_0005, bcyc, dn, tmo);
        model(MD_MULTU, 32'h0001_0003, 32'h0002_0005, eh, el);
        vectors++; if (lo !== el || hi !== eh) begin errors++; $display("FAIL b2b_first: got %h_%h expected %h_%h", hi, lo, eh, el); end
        launch(MD_MULT, 32'hFFFF_FFF0, 32'h0000_0100, bcyc, dn, tmo);
        model(MD_MULT, 32'hFFFF_FFF0, 32'h0000_0100, eh, el);
        vectors++; if (tmo || bcyc != 33 || dn !== 1'b1) begin errors++; $display("FAIL b2b_timing: busy %0d done %b expected 33 and 1", bcyc, dn); end
        vectors++; if (lo !== el || hi !== eh) begin errors++; $display("FAIL b2b_second: got %h_%h expected %h_%h", hi, lo, eh, el); end
    endtask

    task automatic test_write_with_start;
        logic [31:0] eh, el;
        int bcyc; bit tmo;
        model(MD_MULTU, 32'd1000, 32'd3000, eh, el);
        start = 1'b1; op = MD_MULTU; a = 32'd1000; b = 32'd3000;
        hi_we = 1'b1; lo_we = 1'b1; wdata = 32'h0000_0055;
        @(posedge clk); #1 start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
        vectors++; if (hi !== 32'h55 || lo !== 32'h55) begin errors++; $display("FAIL mt_with_start_write: got %h_%h expected 55_55", hi, lo); end
        @(negedge clk);
        bcyc = 0;
        wait_idle(bcyc, tmo);
        vectors++; if (tmo || lo !== el || hi !== eh) begin errors++; $display("FAIL mt_with_start_result: got %h_%h expected %h_%h", hi, lo, eh, el); end
    endtask

    task automatic test_hazard;
        logic [31:0] eh, el;
        int bcyc; bit tmo;
        mt_write(32'h5555_5555, 32'h6666_6666);
        model(MD_MULTU, 32'h0012_3456, 32'h0000_0789, eh, el);
        start = 1'b1; op = MD_MULTU; a = 32'h0012_3456; b = 32'h0000_0789;
        @(posedge clk); #1 start = 1'b0;
        bcyc = 0;
        repeat (10) begin @(negedge clk); if (busy) bcyc++; end
        vectors++; if (hi !== 32'h5555_5555 || lo !== 32'h6666_6666) begin
            errors++; $display("FAIL hazard_midop_hilo: got %h_%h expected 55555555_66666666", hi, lo);
        end
        start = 1'b1; op = MD_MULT; a = 32'hFFFF_0000; b = 32'h0000_0003;
        hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hAA;
        @(posedge clk); #1 start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
        @(negedge clk);
        wait_idle(bcyc, tmo);
        vectors++; if (tmo || bcyc != 33) begin errors++; $display("FAIL hazard_busy_cycles: got %0d expected 33", bcyc); end
        vectors++; if (hi !== eh || lo !== el) begin errors++; $display("FAIL hazard_result: got %h_%h expected %h_%h", hi, lo, eh, el); end
        @(negedge clk);
        vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL hazard_no_queue: got busy %b expected 0", busy); end
    endtask

    task automatic test_reset_mid;
        bit seen;
        mt_write(32'h1111_1111, 32'h2222_2222);
        start = 1'b1; op = DIV_EN ? MD_DIV : MD_MULT; a = 32'hFFFF_0001; b = 32'h0000_0013;
        @(posedge clk); #1 start = 1'b0;
        repeat (20) @(negedge clk);
        vectors++; if (busy !== 1'b1) begin errors++; $display("FAIL rstmid_running: got busy %b expected 1", busy); end
        rst = 1'b1;
        #1;
        vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b expected 0", busy); end
        vectors++; if (hi !== 32'h0 || lo !== 32'h0) begin errors++; $display("FAIL rstmid_hilo: got %h_%h expected 0_0", hi, lo); end
        @(negedge clk); rst = 1'b0;
        seen = 1'b0;
        repeat (40) begin @(negedge clk); if (done || busy) seen = 1'b1; end
        vectors++; if (seen) begin errors++; $display("FAIL rstmid_no_done: got activity 1 expected 0"); end
    endtask

    task automatic test_div_disabled;
        bit seen;
        mt_write(32'h1234_5678, 32'h9ABC_DEF0);
        for (int k = 0; k < 2; k++) begin
            start = 1'b1; op = (k == 0) ? MD_DIV : MD_DIVU; a = 32'h0000_0064; b = 32'h0000_0007;
            @(posedge clk); #1 start = 1'b0;
            seen = 1'b0;
            repeat (40) begin @(negedge clk); if (busy || done) seen = 1'b1; end
            vectors++; if (seen) begin errors++; $display("FAIL nodiv%0d_activity: got busy/done 1 expected 0", k); end
            vectors++; if (hi !== 32'h1234_5678 || lo !== 32'h9ABC_DEF0) begin
                errors++; $display("FAIL nodiv%0d_hilo: got %h_%h expected 12345678_9abcdef0", k, hi, lo);
            end
        end
    endtask

    initial begin
        test_reset();
        test_mthi_mtlo();
        test_directed();
        test_random();
        test_back_to_back();
        test_write_with_start();
        test_hazard();
        test_reset_mid();
        if (!DIV_EN) test_div_disabled();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
